// File: rtl/cic_fir_pkg.sv
// Shared constants, coefficient table, FSM state type and width helper for
// the CIC droop-compensation FIR.
package cic_fir_pkg;

  localparam int COEF_W    = 12;
  localparam int NUM_TAPS  = 7;
  localparam int NUM_PAIRS = 3;
  localparam int SHIFT     = 8;

  // Half of a symmetric 7-tap kernel: COEF[0..2] pair outer taps, COEF[3] is
  // the centre tap. The full kernel sums to 2^SHIFT (unity DC gain).
  localparam logic signed [COEF_W-1:0] COEF [0:NUM_PAIRS] =
    '{-12'sd8, 12'sd0, 12'sd72, 12'sd128};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  // Pair sum (data + 2) times coefficient, plus 2 guard bits so four
  // accumulated products can never wrap.
  function automatic int acc_width(input int data_width);
    return data_width + 2 + COEF_W + 2;
  endfunction

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and unsigned clamp of the
// signed accumulator into the output sample range.
module cic_round_sat #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 20,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic        [OUT_W-1:0] data_o
);

  // One extra bit keeps the rounding add from overflowing.
  localparam logic signed [IN_W:0] HALF =
    {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_OUT =
    {{(IN_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic signed [IN_W:0] acc_ext;
  logic signed [IN_W:0] shifted;

  assign acc_ext = {acc_i[IN_W-1], acc_i};
  assign shifted = (acc_ext + HALF) >>> SHIFT;

  // Clamp negatives to zero and large values to full scale.
  always_comb begin
    data_o = shifted[OUT_W-1:0];
    if (shifted[IN_W]) begin
      data_o = '0;
    end else if (shifted > MAX_OUT) begin
      data_o = '1;
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR behind the CIC decimator: strobe edge detect, 7-tap
// delay line, serial 4-cycle symmetric MAC, round/saturate and a one-deep
// valid/ready output register with sticky overrun/drop flags.
module cic_comp_fir
  import cic_fir_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int DECIM      = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] cic_data_i,
  input  logic                  cic_clk_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  drop_o,
  input  logic                  err_clr_i
);

  localparam int ACC_W  = acc_width(DATA_WIDTH);
  localparam int PAIR_W = DATA_WIDTH + 2;
  localparam int PROD_W = PAIR_W + COEF_W;

  logic                         cic_clk_prev_reg;
  logic                         strobe_edge;
  logic                         accept;
  logic                         start_mac;
  logic                         sat_load;
  logic                         phase_reg;
  state_t                       state_reg, state_next;
  logic [1:0]                   mac_idx_reg, mac_idx_next;
  logic [DATA_WIDTH-1:0]        x_reg [NUM_TAPS];
  logic signed [PAIR_W-1:0]     x_ext [NUM_TAPS];
  logic signed [PAIR_W-1:0]     pair_sum;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_term;
  logic signed [ACC_W-1:0]      acc_reg;
  logic [DATA_WIDTH-1:0]        sat_data;

  assign strobe_edge = cic_clk_i && !cic_clk_prev_reg;
  assign accept      = strobe_edge && (state_reg == IDLE);
  assign start_mac   = accept && !phase_reg;
  assign sat_load    = (state_reg == SAT);

  // Register the strobe so a rising edge can be detected in the clk_i domain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cic_clk_prev_reg <= 1'b0;
    else         cic_clk_prev_reg <= cic_clk_i;
  end

  // Shift accepted samples into the delay line; samples arriving mid-MAC are
  // discarded so the taps stay stable for the whole MAC pass.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_TAPS; i++) x_reg[i] <= '0;
    end else if (accept) begin
      x_reg[0] <= cic_data_i;
      for (int i = 1; i < NUM_TAPS; i++) x_reg[i] <= x_reg[i-1];
    end
  end

  // Zero-extend every tap to a signed operand wide enough for a pair sum.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_ext
    assign x_ext[gi] = $signed({2'b00, x_reg[gi]});
  end

  // Decimation phase: only phase-0 samples launch a MAC pass.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     phase_reg <= 1'b0;
    else if (accept) phase_reg <= (DECIM == 2) ? ~phase_reg : 1'b0;
  end

  // FSM state and MAC index register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg   <= IDLE;
      mac_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mac_idx_reg <= mac_idx_next;
    end
  end

  // Next-state logic: IDLE -> MAC (k = 0..3) -> SAT -> IDLE.
  always_comb begin
    state_next   = state_reg;
    mac_idx_next = mac_idx_reg;
    case (state_reg)
      IDLE: begin
        if (start_mac) begin
          state_next   = MAC;
          mac_idx_next = '0;
        end
      end
      MAC: begin
        if (mac_idx_reg == 2'd3) state_next = SAT;
        else                     mac_idx_next = mac_idx_reg + 2'd1;
      end
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Select the symmetric tap pair (or the centre tap) for this MAC step.
  always_comb begin
    pair_sum = '0;
    case (mac_idx_reg)
      2'd0:    pair_sum = x_ext[0] + x_ext[6];
      2'd1:    pair_sum = x_ext[1] + x_ext[5];
      2'd2:    pair_sum = x_ext[2] + x_ext[4];
      default: pair_sum = x_ext[3];
    endcase
  end

  assign prod     = pair_sum * COEF[mac_idx_reg];
  assign acc_term = ACC_W'(prod);

  // Accumulate one product per MAC cycle; cleared as the pass starts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                 acc_reg <= '0;
    else if (start_mac)          acc_reg <= '0;
    else if (state_reg == MAC)   acc_reg <= acc_reg + acc_term;
  end

  cic_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_WIDTH),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i  (acc_reg),
    .data_o (sat_data)
  );

  // Output register: a new result always wins over holding the old one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (sat_load) begin
      data_o  <= sat_data;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the clear cycle takes priority.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      if (sat_load && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (err_clr_i)                  overrun_o <= 1'b0;
      if (strobe_edge && state_reg != IDLE) drop_o <= 1'b1;
      else if (err_clr_i)                   drop_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: DUT1 (DECIM=1) covers DC, impulse,
// saturation, drop and reset; DUT2 (DECIM=2) covers backpressure/overrun.
module tb_cic_comp_fir;

  localparam int DW = 20;
  localparam longint FULL = 1048575;

  logic clk = 1'b0;
  logic rstn;
  logic [DW-1:0] cic1_data, cic2_data, data1, data2;
  logic cic1_clk, cic2_clk, valid1, valid2, ready1, ready2;
  logic overrun1, overrun2, drop1, drop2, err_clr1, err_clr2;

  always #5 clk = ~clk;

  cic_comp_fir #(.DATA_WIDTH(DW), .DECIM(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .cic_data_i(cic1_data), .cic_clk_i(cic1_clk),
    .data_o(data1), .valid_o(valid1), .ready_i(ready1),
    .overrun_o(overrun1), .drop_o(drop1), .err_clr_i(err_clr1));

  cic_comp_fir #(.DATA_WIDTH(DW), .DECIM(2)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .cic_data_i(cic2_data), .cic_clk_i(cic2_clk),
    .data_o(data2), .valid_o(valid2), .ready_i(ready2),
    .overrun_o(overrun2), .drop_o(drop2), .err_clr_i(err_clr2));

  typedef struct {
    longint data;
    longint edge_cyc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  longint cyc = 0;
  longint last_mac1 = -100;
  logic drop_model = 1'b0;
  logic [6:0][DW-1:0] m1 = '0;
  logic [6:0][DW-1:0] m2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: symmetric 7-tap kernel, round half up, >>> 8, clamp.
  function automatic longint fir_ref(input logic [6:0][DW-1:0] x);
    longint acc, r;
    acc = -8 * (longint'(x[0]) + longint'(x[6]))
        + 72 * (longint'(x[2]) + longint'(x[4]))
        + 128 * longint'(x[3]);
    r = (acc + 128) >>> 8;
    if (r < 0) r = 0;
    if (r > FULL) r = FULL;
    return r;
  endfunction

  // One strobe of `period` clocks. edge_cyc is the count of the posedge that
  // samples the edge (end of edge cycle T); the result must be visible after
  // the 5th posedge following it, i.e. in cycle T+6.
  task automatic strobe(input int which, input longint v, input int period);
    longint edge_cyc;
    exp_t e;
    @(negedge clk);
    edge_cyc = cyc + 1;
    if (which == 1) begin
      cic1_data = DW'(v);
      cic1_clk  = 1'b1;
      if (edge_cyc - last_mac1 >= 6) begin
        m1 = {m1[5:0], DW'(v)};
        e.data = fir_ref(m1);
        e.edge_cyc = edge_cyc;
        q.push_back(e);
        last_mac1 = edge_cyc;
      end else begin
        drop_model = 1'b1;
      end
    end else begin
      cic2_data = DW'(v);
      cic2_clk  = 1'b1;
      m2 = {m2[5:0], DW'(v)};
    end
    @(negedge clk);
    cic1_clk = 1'b0;
    cic2_clk = 1'b0;
    repeat (period - 2) @(negedge clk);
  endtask

  // Scoreboard monitor for DUT1: pop on every accepted result.
  always @(negedge clk) begin
    if (rstn && valid1 && ready1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("out data=%0d exp=%0d latency=%0d", data1, e.data, cyc - e.edge_cyc);
        chk("data", longint'(data1), e.data);
        chk("latency", cyc - e.edge_cyc, 5);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint exp_a, exp_b;
    rstn = 1'b0;
    cic1_data = '0; cic2_data = '0; cic1_clk = 1'b0; cic2_clk = 1'b0;
    ready1 = 1'b1; ready2 = 1'b1; err_clr1 = 1'b0; err_clr2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", longint'(data1), 0);
    chk("rst_valid", longint'(valid1), 0);
    chk("rst_overrun", longint'(overrun1), 0);
    chk("rst_drop", longint'(drop1), 0);
    chk("rst_valid2", longint'(valid2), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // DECIM=2 backpressure: warm up, then hold ready low for 4 strobes.
    for (int i = 0; i < 10; i++) strobe(2, 1000, 10);
    ready2 = 1'b0;
    strobe(2, 2000, 10);
    exp_a = fir_ref(m2);
    strobe(2, 2000, 10);
    chk("bp_valid_a", longint'(valid2), 1);
    chk("bp_data_a", longint'(data2), exp_a);
    chk("bp_overrun_a", longint'(overrun2), 0);
    strobe(2, 2000, 10);
    exp_b = fir_ref(m2);
    strobe(2, 2000, 10);
    chk("bp_data_b", longint'(data2), exp_b);
    chk("bp_valid_b", longint'(valid2), 1);
    chk("bp_overrun_b", longint'(overrun2), 1);
    err_clr2 = 1'b1;
    @(negedge clk);
    err_clr2 = 1'b0;
    chk("bp_overrun_clr", longint'(overrun2), 0);
    ready2 = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", longint'(valid2), 0);

    // DC run.
    for (int i = 0; i < 10; i++) strobe(1, 1000, 10);
    chk("dc_drop", longint'(drop1), 0);
    // Impulse on a 1000 baseline.
    strobe(1, 1256, 10);
    for (int i = 0; i < 8; i++) strobe(1, 1000, 10);
    // Saturation: zeros then full-scale step.
    for (int i = 0; i < 8; i++) strobe(1, 0, 10);
    for (int i = 0; i < 10; i++) strobe(1, FULL, 10);
    // Drop: period 4, alternate edges land in MAC.
    for (int i = 0; i < 6; i++) strobe(1, 100 * (i + 1), 4);
    repeat (10) @(negedge clk);
    chk("drop_set", longint'(drop1), longint'(drop_model));
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    drop_model = 1'b0;
    chk("drop_clr", longint'(drop1), 0);
    for (int i = 0; i < 3; i++) strobe(1, 3000, 10);

    // Reset two cycles into MAC: in-flight result is abandoned.
    @(negedge clk);
    cic1_data = DW'(777);
    cic1_clk  = 1'b1;
    @(negedge clk);
    cic1_clk  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", longint'(data1), 0);
    chk("mid_rst_valid", longint'(valid1), 0);
    q.delete();
    m1 = '0;
    last_mac1 = -100;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) strobe(1, 500, 10);
    repeat (10) @(negedge clk);
    chk("post_rst_last", longint'(data1), 500);
    chk("drain", q.size(), 0);
    chk("no_overrun1", longint'(overrun1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
